// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared constants and helpers for the seven-segment scan driver
//
// Purpose: segment bit positions, the active-high hex glyph table and the
// digit-index width helper used by seg7_hex_enc and seg7_scan_driver.
// Ports: none (package).
package seg7_pkg;

  // Bit positions inside the 8-bit segment vector {dp,g,f,e,d,c,b,a}
  localparam int SEG_A  = 0;
  localparam int SEG_B  = 1;
  localparam int SEG_C  = 2;
  localparam int SEG_D  = 3;
  localparam int SEG_E  = 4;
  localparam int SEG_F  = 5;
  localparam int SEG_G  = 6;
  localparam int SEG_DP = 7;

  // Internal vectors are active-high, so "everything off" is all zeros
  localparam logic [7:0] SEG_ALL_OFF_INT = 8'h00;

  // Active-high glyphs {g,f,e,d,c,b,a} for 0123456789AbCdEF
  localparam logic [6:0] GLYPH_TAB [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  // Digit index width; a single-digit display still needs one bit
  function automatic int idx_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/seg7_hex_enc.sv
// rtl/seg7_hex_enc.sv - combinational nibble to active-high seven-segment glyph
//
// Purpose: decode one hex nibble into the standard 0-F glyph.
// Ports:
//   nibble_i  4-bit hex digit
//   glyph_o   7-bit active-high segments {g,f,e,d,c,b,a}
module seg7_hex_enc
  import seg7_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] glyph_o
);

  logic [6:0] raw;

  always_comb begin
    raw     = GLYPH_TAB[nibble_i];
    glyph_o = {raw[SEG_G], raw[SEG_F], raw[SEG_E], raw[SEG_D],
               raw[SEG_C], raw[SEG_B], raw[SEG_A]};
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// rtl/seg7_scan_driver.sv - multi-digit multiplexed seven-segment display driver
//
// Purpose: scans an N-digit hex word onto one shared segment bus with one-hot
// digit enables; frame-synchronous tear-free loading, leading-zero blanking
// and whole-display blink.
// Ports:
//   iCLK, iRST_N   clock, asynchronous active-low reset
//   iVALUE, iDP    hex word (nibble k -> digit k) and per-digit decimal points
//   iLOAD          strobe capturing iVALUE/iDP, applied at the next frame end
//   iBLANK_LZ      leading-zero blanking enable
//   iBLINK_EN      whole-display blink enable
//   oSEG, oAN      registered segment bus {dp,g..a} and digit enables
//   oFRAME         one-cycle pulse after the last digit's slot ends
//   oPENDING       a loaded value waits for the next frame boundary
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS     = 4,
  parameter int SCAN_DIV       = 50000,
  parameter int BLINK_FRAMES   = 64,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit AN_ACTIVE_LOW  = 1'b1
) (
  input  logic                    iCLK,
  input  logic                    iRST_N,
  input  logic [4*NUM_DIGITS-1:0] iVALUE,
  input  logic [NUM_DIGITS-1:0]   iDP,
  input  logic                    iLOAD,
  input  logic                    iBLANK_LZ,
  input  logic                    iBLINK_EN,
  output logic [7:0]              oSEG,
  output logic [NUM_DIGITS-1:0]   oAN,
  output logic                    oFRAME,
  output logic                    oPENDING
);

  if (SCAN_DIV < 2 || NUM_DIGITS < 1 || NUM_DIGITS > 8 || BLINK_FRAMES < 1) begin : g_bad_param
    $error("seg7_scan_driver: illegal parameter value");
  end

  localparam int IW = idx_width(NUM_DIGITS);
  localparam int PW = $clog2(SCAN_DIV);
  localparam int BW = $clog2(BLINK_FRAMES + 1);
  localparam logic [7:0]            SEG_OFF_PIN = SEG_ACTIVE_LOW ? 8'hFF : 8'h00;
  localparam logic [NUM_DIGITS-1:0] AN_OFF_PIN  = AN_ACTIVE_LOW ? '1 : '0;

  logic [PW-1:0]           presc_q, presc_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] disp_q, disp_d, shv_q, shv_d;
  logic [NUM_DIGITS-1:0]   dpr_q, dpr_d, shdp_q, shdp_d;
  logic                    pend_q, pend_d;
  logic [BW-1:0]           bcnt_q, bcnt_d;
  logic                    phase_q, phase_d;   // 1 = hidden half of the blink
  logic [7:0]              seg_q, seg_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic                    frame_q, frame_d;

  logic                    tick, frame_end, hidden, zero_run, cur_dp, cur_blank;
  logic [NUM_DIGITS-1:0]   blank, an_int;
  logic [3:0]              cur_nib;
  logic [6:0]              glyph;
  logic [7:0]              seg_int;

  seg7_hex_enc u_enc (
    .nibble_i (cur_nib),
    .glyph_o  (glyph)
  );

  always_comb begin
    tick      = (presc_q == PW'(SCAN_DIV - 1));
    frame_end = tick && (idx_q == IW'(NUM_DIGITS - 1));
    presc_d   = tick ? '0 : presc_q + 1'b1;
    idx_d     = idx_q;
    if (tick) idx_d = frame_end ? '0 : idx_q + 1'b1;
    frame_d   = frame_end;

    // Shadow/pending: a load landing on the frame-end edge bypasses the shadow
    disp_d = disp_q;
    dpr_d  = dpr_q;
    shv_d  = shv_q;
    shdp_d = shdp_q;
    pend_d = pend_q;
    if (iLOAD) begin
      shv_d  = iVALUE;
      shdp_d = iDP;
    end
    if (frame_end && iLOAD) begin
      disp_d = iVALUE;
      dpr_d  = iDP;
      pend_d = 1'b0;
    end else if (frame_end && pend_q) begin
      disp_d = shv_q;
      dpr_d  = shdp_q;
      pend_d = 1'b0;
    end else if (iLOAD) begin
      pend_d = 1'b1;
    end

    bcnt_d  = bcnt_q;
    phase_d = phase_q;
    if (!iBLINK_EN) begin
      bcnt_d  = '0;
      phase_d = 1'b0;
    end else if (frame_end) begin
      if (bcnt_q == BW'(BLINK_FRAMES - 1)) begin
        bcnt_d  = '0;
        phase_d = ~phase_q;
      end else begin
        bcnt_d = bcnt_q + 1'b1;
      end
    end

    // Zero run from the top digit down; a set dp ends the run at that digit
    blank    = '0;
    zero_run = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      zero_run = zero_run && (disp_q[4*k +: 4] == 4'h0) && !dpr_q[k];
      blank[k] = iBLANK_LZ && zero_run && (k != 0);
    end

    cur_nib   = 4'h0;
    cur_dp    = 1'b0;
    cur_blank = 1'b0;
    an_int    = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (idx_q == IW'(k)) begin
        cur_nib   = disp_q[4*k +: 4];
        cur_dp    = dpr_q[k];
        cur_blank = blank[k];
        an_int[k] = 1'b1;
      end
    end

    seg_int = cur_blank ? SEG_ALL_OFF_INT : {cur_dp, glyph};
    // Uses the live enable so dropping blink shows the display on the next edge
    hidden  = iBLINK_EN && phase_q;
    seg_d   = hidden ? SEG_OFF_PIN : (SEG_ACTIVE_LOW ? ~seg_int : seg_int);
    an_d    = hidden ? AN_OFF_PIN : (AN_ACTIVE_LOW ? ~an_int : an_int);
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      presc_q <= '0;
      idx_q   <= '0;
      disp_q  <= '0;
      dpr_q   <= '0;
      shv_q   <= '0;
      shdp_q  <= '0;
      pend_q  <= 1'b0;
      bcnt_q  <= '0;
      phase_q <= 1'b0;
      seg_q   <= SEG_OFF_PIN;
      an_q    <= AN_OFF_PIN;
      frame_q <= 1'b0;
    end else begin
      presc_q <= presc_d;
      idx_q   <= idx_d;
      disp_q  <= disp_d;
      dpr_q   <= dpr_d;
      shv_q   <= shv_d;
      shdp_q  <= shdp_d;
      pend_q  <= pend_d;
      bcnt_q  <= bcnt_d;
      phase_q <= phase_d;
      seg_q   <= seg_d;
      an_q    <= an_d;
      frame_q <= frame_d;
    end
  end

  assign oSEG     = seg_q;
  assign oAN      = an_q;
  assign oFRAME   = frame_q;
  assign oPENDING = pend_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb/tb_seg7_scan_driver.sv - self-checking bench for seg7_scan_driver
module tb_seg7_scan_driver;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] value;
  logic [3:0]  dp;
  logic        load, blz, blink;
  logic [7:0]  seg;
  logic [3:0]  an;
  logic        frame, pend;

  always #5 clk = ~clk;

  seg7_scan_driver #(
    .NUM_DIGITS(4), .SCAN_DIV(4), .BLINK_FRAMES(2),
    .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1)
  ) dut (
    .iCLK(clk), .iRST_N(rst_n), .iVALUE(value), .iDP(dp), .iLOAD(load),
    .iBLANK_LZ(blz), .iBLINK_EN(blink), .oSEG(seg), .oAN(an),
    .oFRAME(frame), .oPENDING(pend)
  );

  typedef struct packed {
    logic [15:0] value;
    logic [3:0]  dp;
    logic        blz;
    logic [31:0] exp_seg;   // {digit3, digit2, digit1, digit0}
  } vec_t;

  vec_t       vecs [10];
  int         n_pass = 0;
  int         n_total = 0;
  logic [7:0] fr_seg [4];
  logic [3:0] fr_an [4];
  logic [3:0] an_exp;
  int         gap;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h required %h", name, got, exp);
  endtask

  // Returns on the negedge where oFRAME is seen high
  task automatic wait_frame();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (frame !== 1'b1 && n < 60);
    chk("frame_seen", {31'd0, frame}, 32'd1);
  endtask

  // Digit k's slot spans negedges N0+1+4k .. N0+4+4k after the frame pulse
  task automatic capture_frame();
    wait_frame();
    repeat (2) @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      fr_seg[k] = seg;
      fr_an[k]  = an;
      if (k < 3) repeat (4) @(negedge clk);
    end
  endtask

  task automatic load_val(input logic [15:0] v, input logic [3:0] d);
    value = v;
    dp    = d;
    load  = 1'b1;
    @(negedge clk);
    load  = 1'b0;
  endtask

  initial begin
    vecs[0] = '{16'h0000, 4'b0000, 1'b0, 32'hC0C0C0C0};
    vecs[1] = '{16'h12AF, 4'b0000, 1'b0, 32'hF9A4888E};
    vecs[2] = '{16'h0050, 4'b0000, 1'b1, 32'hFFFF92C0};
    vecs[3] = '{16'h0000, 4'b0000, 1'b1, 32'hFFFFFFC0};
    vecs[4] = '{16'h0000, 4'b0100, 1'b1, 32'hFF40C0C0};
    vecs[5] = '{16'h8E30, 4'b0001, 1'b1, 32'h8086B040};
    vecs[6] = '{16'h7BCD, 4'b0000, 1'b0, 32'hF883C6A1};
    vecs[7] = '{16'h4689, 4'b0000, 1'b0, 32'h99828090};
    vecs[8] = '{16'h0001, 4'b0000, 1'b1, 32'hFFFFFFF9};
    vecs[9] = '{16'h0E00, 4'b1000, 1'b1, 32'h4086C0C0};

    rst_n = 1'b0; value = '0; dp = '0; load = 1'b0; blz = 1'b0; blink = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_seg", {24'd0, seg}, 32'hFF);
    chk("rst_an", {28'd0, an}, 32'hF);
    chk("rst_frame", {31'd0, frame}, 32'd0);
    chk("rst_pend", {31'd0, pend}, 32'd0);

    // First edge after release shows digit 0; digit 1 appears four edges later
    rst_n = 1'b1;
    @(negedge clk);
    chk("first_an", {28'd0, an}, 32'hE);
    chk("first_seg", {24'd0, seg}, 32'hC0);
    repeat (4) @(negedge clk);
    chk("second_an", {28'd0, an}, 32'hD);

    wait_frame();
    gap = 0;
    do begin
      @(negedge clk);
      gap++;
    end while (frame !== 1'b1 && gap < 40);
    chk("frame_period", gap, 32'd16);
    @(negedge clk);
    chk("frame_width", {31'd0, frame}, 32'd0);

    // Mid-frame load stays pending until the frame end
    repeat (4) @(negedge clk);
    load_val(16'h12AF, 4'b0000);
    chk("pend_set", {31'd0, pend}, 32'd1);
    wait_frame();
    chk("pend_clr", {31'd0, pend}, 32'd0);
    repeat (2) @(negedge clk);
    chk("pend_d0_seg", {24'd0, seg}, 32'h8E);

    for (int i = 0; i < 10; i++) begin
      blz = vecs[i].blz;
      load_val(vecs[i].value, vecs[i].dp);
      capture_frame();
      for (int k = 0; k < 4; k++) begin
        an_exp = ~(4'b0001 << k);
        chk($sformatf("v%0d_d%0d_seg", i, k), {24'd0, fr_seg[k]}, {24'd0, vecs[i].exp_seg[8*k +: 8]});
        chk($sformatf("v%0d_d%0d_an", i, k), {28'd0, fr_an[k]}, {28'd0, an_exp});
      end
    end
    blz = 1'b0;

    // Two loads in one frame: the second wins
    wait_frame();
    repeat (3) @(negedge clk);
    load_val(16'h1111, 4'b0000);
    load_val(16'h2222, 4'b0000);
    chk("lastwin_pend", {31'd0, pend}, 32'd1);
    capture_frame();
    for (int k = 0; k < 4; k++)
      chk($sformatf("lastwin_d%0d_seg", k), {24'd0, fr_seg[k]}, 32'hA4);

    // Load on the frame-end edge goes straight to the display
    wait_frame();
    repeat (15) @(negedge clk);
    value = 16'h3333;
    dp    = 4'b0000;
    load  = 1'b1;
    @(negedge clk);
    load  = 1'b0;
    chk("coinc_frame", {31'd0, frame}, 32'd1);
    chk("coinc_pend", {31'd0, pend}, 32'd0);
    @(negedge clk);
    chk("coinc_an", {28'd0, an}, 32'hE);
    chk("coinc_seg", {24'd0, seg}, 32'hB0);

    // Blink: visible after frame ends 1,4,5 and hidden after 2,3,6
    blink = 1'b1;
    for (int f = 1; f <= 6; f++) begin
      wait_frame();
      repeat (2) @(negedge clk);
      if (f == 1 || f == 4 || f == 5) begin
        chk($sformatf("blink%0d_an", f), {28'd0, an}, 32'hE);
        chk($sformatf("blink%0d_seg", f), {24'd0, seg}, 32'hB0);
      end else begin
        chk($sformatf("blink%0d_an", f), {28'd0, an}, 32'hF);
        chk($sformatf("blink%0d_seg", f), {24'd0, seg}, 32'hFF);
      end
    end
    blink = 1'b0;
    @(negedge clk);
    chk("unblink_an", {28'd0, an}, 32'hE);
    chk("unblink_seg", {24'd0, seg}, 32'hB0);

    // Asynchronous reset mid-scan discards a pending load
    wait_frame();
    repeat (5) @(negedge clk);
    load_val(16'h5555, 4'b0000);
    chk("rst2_pend_before", {31'd0, pend}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst2_an", {28'd0, an}, 32'hF);
    chk("rst2_seg", {24'd0, seg}, 32'hFF);
    chk("rst2_pend", {31'd0, pend}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    capture_frame();
    for (int k = 0; k < 4; k++)
      chk($sformatf("rst2_d%0d_seg", k), {24'd0, fr_seg[k]}, 32'hC0);
    chk("rst2_pend_after", {31'd0, pend}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
